// File: rtl/sum_fifo.sv
// sum_fifo: first-word fall-through FIFO for {sum, zero-flag} words coming
// from a registered adder stage. It reports its occupancy and has a sticky
// overflow flag.
// Optional feature: define SUM_FIFO_ZCNT_EN to add a saturating 16-bit
// counter of accepted zero words (zcnt) and its synchronous clear (zcnt_clr).
module sum_fifo #(
  parameter int unsigned SWIDTH = 9,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [SWIDTH-1:0] in_sum,
  input  logic              in_zero,
  output logic              in_rdy,
  output logic              out_vld,
  output logic [SWIDTH-1:0] out_sum,
  output logic              out_zero,
  input  logic              out_rdy,
  output logic [AW:0]       level,
`ifdef SUM_FIFO_ZCNT_EN
  output logic [15:0]       zcnt,
  input  logic              zcnt_clr,
`endif
  output logic              ovf
);

  localparam int unsigned DW = SWIDTH + 1;
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;

  // Handshake flags are decoded from registered occupancy only.
  assign in_rdy  = (level_q != LW'(DEPTH));
  assign out_vld = (level_q != '0);
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;

  // The head entry is read straight from storage (fall-through).
  assign {out_sum, out_zero} = mem_q[rd_ptr_q];
  assign level = level_q;
  assign ovf   = ovf_q;

  // Next-state for the pointers, the occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q | (in_vld & ~in_rdy);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state register; the async reset discards any entries in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage write; the contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_sum, in_zero};
  end

`ifdef SUM_FIFO_ZCNT_EN
  logic [15:0] zcnt_q, zcnt_d;

  // Saturating zero-word counter; a clear wins over a same-cycle increment.
  always_comb begin
    zcnt_d = zcnt_q;
    if (zcnt_clr)
      zcnt_d = '0;
    else if (push && in_zero && (zcnt_q != 16'hFFFF))
      zcnt_d = zcnt_q + 16'd1;
  end

  // Zero-word counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) zcnt_q <= '0;
    else     zcnt_q <= zcnt_d;
  end

  assign zcnt = zcnt_q;
`endif

endmodule
